// File: rtl/reg_bank_if.sv
// Bundles the two requester ports of the shared register bank.
// The master side drives requests; the slave side is the arbiter.
interface reg_bank_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
);
    logic              req0;
    logic              we0;
    logic              lock0;
    logic [ADDR_W-1:0] addr0;
    logic [WIDTH-1:0]  wdata0;
    logic              gnt0;
    logic [WIDTH-1:0]  rdata0;
    logic              rvalid0;

    logic              req1;
    logic              we1;
    logic              lock1;
    logic [ADDR_W-1:0] addr1;
    logic [WIDTH-1:0]  wdata1;
    logic              gnt1;
    logic [WIDTH-1:0]  rdata1;
    logic              rvalid1;

    modport master (
        output req0, we0, lock0, addr0, wdata0,
        output req1, we1, lock1, addr1, wdata1,
        input  gnt0, rdata0, rvalid0,
        input  gnt1, rdata1, rvalid1
    );

    modport slave (
        input  req0, we0, lock0, addr0, wdata0,
        input  req1, we1, lock1, addr1, wdata1,
        output gnt0, rdata0, rvalid0,
        output gnt1, rdata1, rvalid1
    );
endinterface

// File: rtl/reg_bank_arbiter.sv
// Two-requester round-robin arbiter with burst lock in front of a DEPTH x WIDTH
// register bank; one read or write is serviced per clock.
module reg_bank_arbiter #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic       clk,
    input  logic       reset,
    reg_bank_if.slave  bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOCK0 = 2'd1;
    localparam logic [1:0] LOCK1 = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             prio;       // 0: requester 0 wins a tie, 1: requester 1
    logic             prio_nxt;
    logic             hold;
    logic             gnt0;
    logic             gnt1;
    logic [WIDTH-1:0] entry [DEPTH];
    logic [WIDTH-1:0] rdata0_q;
    logic [WIDTH-1:0] rdata1_q;
    logic             rvalid0_q;
    logic             rvalid1_q;

    logic             hit0;
    logic             hit1;
    logic [IDX_W-1:0] idx0;
    logic [IDX_W-1:0] idx1;
    logic [WIDTH-1:0] rd0;
    logic [WIDTH-1:0] rd1;

    assign hit0 = {1'b0, bus.addr0} < DEPTH_L;
    assign hit1 = {1'b0, bus.addr1} < DEPTH_L;
    assign idx0 = bus.addr0[IDX_W-1:0];
    assign idx1 = bus.addr1[IDX_W-1:0];
    assign rd0  = hit0 ? entry[idx0] : '0;
    assign rd1  = hit1 ? entry[idx1] : '0;

    always_comb begin
        // NOTE: every signal gets a default first, so no path can leave one unassigned and infer a latch.
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        hold      = 1'b0;
        state_nxt = state;
        prio_nxt  = prio;
        if (!reset) begin
            // The lock owner keeps the bank while requesting; otherwise arbitrate fresh.
            if (state == LOCK0 && bus.req0) begin
                gnt0 = 1'b1;
                hold = bus.lock0;
            end else if (state == LOCK1 && bus.req1) begin
                gnt1 = 1'b1;
                hold = bus.lock1;
            end else if (bus.req0 && (!bus.req1 || !prio)) begin
                gnt0 = 1'b1;
            end else if (bus.req1) begin
                gnt1 = 1'b1;
            end

            if (!hold) begin
                state_nxt = IDLE;
                if (gnt0) begin
                    prio_nxt = 1'b1;
                    if (bus.lock0) state_nxt = LOCK0;
                end else if (gnt1) begin
                    prio_nxt = 1'b0;
                    if (bus.lock1) state_nxt = LOCK1;
                end
            end
        end
    end

    // NOTE: all state here uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            prio      <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            // NOTE: the bank is a flop array, not RAM, so clearing every entry on reset is legal and intended.
            for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
        end else begin
            state     <= state_nxt;
            prio      <= prio_nxt;
            rvalid0_q <= gnt0 && !bus.we0;
            rvalid1_q <= gnt1 && !bus.we1;
            if (gnt0 && !bus.we0) rdata0_q <= rd0;
            if (gnt1 && !bus.we1) rdata1_q <= rd1;
            // Grants are exclusive, so at most one of these loads fires per edge.
            if (gnt0 && bus.we0 && hit0) entry[idx0] <= bus.wdata0;
            if (gnt1 && bus.we1 && hit1) entry[idx1] <= bus.wdata1;
        end
    end

    assign bus.gnt0    = gnt0;
    assign bus.gnt1    = gnt1;
    assign bus.rdata0  = rdata0_q;
    assign bus.rdata1  = rdata1_q;
    assign bus.rvalid0 = rvalid0_q;
    assign bus.rvalid1 = rvalid1_q;
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Table-driven bench for reg_bank_arbiter: per-cycle vectors with expected grants,
// plus a memory model feeding read-data scoreboards for both requesters.
module tb_reg_bank_arbiter;
    localparam int WIDTH  = 16;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 4;

    logic clk = 1'b0;
    logic reset;

    reg_bank_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    reg_bank_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string             tag;
        logic              rst;
        logic              req0, we0, lock0;
        logic [ADDR_W-1:0] addr0;
        logic [WIDTH-1:0]  wdata0;
        logic              req1, we1, lock1;
        logic [ADDR_W-1:0] addr1;
        logic [WIDTH-1:0]  wdata1;
        logic              g0, g1;
    } vec_t;

    int               n_checks = 0;
    int               n_errors = 0;
    vec_t             tbl[$];
    logic [WIDTH-1:0] model [DEPTH];
    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    logic             prev_rst;
    string            prev_tag;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input string tag, input int rst,
                                input int r0, input int w0, input int l0, input int a0, input int d0,
                                input int r1, input int w1, input int l1, input int a1, input int d1,
                                input int g0, input int g1);
        vec_t v;
        v.tag    = tag;
        v.rst    = 1'(rst);
        v.req0   = 1'(r0);
        v.we0    = 1'(w0);
        v.lock0  = 1'(l0);
        v.addr0  = ADDR_W'(a0);
        v.wdata0 = WIDTH'(d0);
        v.req1   = 1'(r1);
        v.we1    = 1'(w1);
        v.lock1  = 1'(l1);
        v.addr1  = ADDR_W'(a1);
        v.wdata1 = WIDTH'(d1);
        v.g0     = 1'(g0);
        v.g1     = 1'(g1);
        return v;
    endfunction

    function automatic logic [WIDTH-1:0] model_rd(input logic [ADDR_W-1:0] a);
        return (int'(a) < DEPTH) ? model[int'(a)] : '0;
    endfunction

    task automatic step(input vec_t v);
        logic [WIDTH-1:0] exp_d;
        @(negedge clk);
        // Outputs produced by the previous edge.
        check({prev_tag, " rvalid0"}, 32'(bus.rvalid0), 32'(q0.size() != 0));
        check({prev_tag, " rvalid1"}, 32'(bus.rvalid1), 32'(q1.size() != 0));
        if (q0.size() != 0) begin
            exp_d = q0.pop_front();
            if (bus.rvalid0) check({prev_tag, " rdata0"}, 32'(bus.rdata0), 32'(exp_d));
        end
        if (q1.size() != 0) begin
            exp_d = q1.pop_front();
            if (bus.rvalid1) check({prev_tag, " rdata1"}, 32'(bus.rdata1), 32'(exp_d));
        end
        if (prev_rst) begin
            check({prev_tag, " reset rdata0"}, 32'(bus.rdata0), 32'h0);
            check({prev_tag, " reset rdata1"}, 32'(bus.rdata1), 32'h0);
        end

        reset      = v.rst;
        bus.req0   = v.req0;
        bus.we0    = v.we0;
        bus.lock0  = v.lock0;
        bus.addr0  = v.addr0;
        bus.wdata0 = v.wdata0;
        bus.req1   = v.req1;
        bus.we1    = v.we1;
        bus.lock1  = v.lock1;
        bus.addr1  = v.addr1;
        bus.wdata1 = v.wdata1;
        #1;
        check({v.tag, " gnt0"}, 32'(bus.gnt0), 32'(v.g0));
        check({v.tag, " gnt1"}, 32'(bus.gnt1), 32'(v.g1));

        // Reference bank: reads see the contents before this edge's load.
        if (v.rst) begin
            for (int i = 0; i < DEPTH; i++) model[i] = '0;
        end else if (v.g0) begin
            if (!v.we0) q0.push_back(model_rd(v.addr0));
            else if (int'(v.addr0) < DEPTH) model[int'(v.addr0)] = v.wdata0;
        end else if (v.g1) begin
            if (!v.we1) q1.push_back(model_rd(v.addr1));
            else if (int'(v.addr1) < DEPTH) model[int'(v.addr1)] = v.wdata1;
        end
        prev_rst = v.rst;
        prev_tag = v.tag;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        bus.req0   = 1'b0; bus.we0 = 1'b0; bus.lock0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1   = 1'b0; bus.we1 = 1'b0; bus.lock1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        prev_rst   = 1'b1;
        prev_tag   = "power_on";
        for (int i = 0; i < DEPTH; i++) model[i] = '0;

        // Reset with requests pending: grants must stay low.
        tbl.push_back(mk("t1_reset_a", 1, 1,0,0,5,0,      1,0,0,5,0,      0,0));
        tbl.push_back(mk("t1_reset_b", 1, 1,0,0,5,0,      1,0,0,5,0,      0,0));
        tbl.push_back(mk("t1_read5",   0, 1,0,0,5,0,      0,0,0,0,0,      1,0));
        // Write then read back on requester 0.
        tbl.push_back(mk("t2_wr3",     0, 1,1,0,3,16'h0003, 0,0,0,0,0,    1,0));
        tbl.push_back(mk("t2_rd3",     0, 1,0,0,3,0,      0,0,0,0,0,      1,0));
        // Both reading continuously after reset: strict alternation from prio 0.
        tbl.push_back(mk("t3_reset",   1, 0,0,0,0,0,      0,0,0,0,0,      0,0));
        tbl.push_back(mk("t3_rr_a",    0, 1,0,0,3,0,      1,0,0,3,0,      1,0));
        tbl.push_back(mk("t3_rr_b",    0, 1,0,0,3,0,      1,0,0,3,0,      0,1));
        tbl.push_back(mk("t3_rr_c",    0, 1,0,0,3,0,      1,0,0,3,0,      1,0));
        tbl.push_back(mk("t3_rr_d",    0, 1,0,0,3,0,      1,0,0,3,0,      0,1));
        // Locked burst by requester 1 while requester 0 waits.
        tbl.push_back(mk("t4_wr7",     0, 1,1,0,7,16'h0707, 0,0,0,0,0,    1,0));
        tbl.push_back(mk("t4_lock_a",  0, 1,0,0,7,0,      1,1,1,0,16'h000F, 0,1));
        tbl.push_back(mk("t4_lock_b",  0, 1,0,0,7,0,      1,1,1,1,16'h000F, 0,1));
        tbl.push_back(mk("t4_lock_c",  0, 1,0,0,7,0,      1,1,1,2,16'h000F, 0,1));
        tbl.push_back(mk("t4_release", 0, 1,0,0,7,0,      0,0,0,0,0,      1,0));
        tbl.push_back(mk("t4_rb0",     0, 0,0,0,0,0,      1,0,0,0,0,      0,1));
        tbl.push_back(mk("t4_rb1",     0, 0,0,0,0,0,      1,0,0,1,0,      0,1));
        tbl.push_back(mk("t4_rb2",     0, 0,0,0,0,0,      1,0,0,2,0,      0,1));
        // Reset during LOCK0 with a read requested in the reset cycle.
        tbl.push_back(mk("t5_lock0",   0, 1,0,1,0,0,      0,0,0,0,0,      1,0));
        tbl.push_back(mk("t5_hold",    0, 1,0,1,1,0,      1,0,0,4,0,      1,0));
        tbl.push_back(mk("t5_reset",   1, 1,0,1,2,0,      1,0,0,4,0,      0,0));
        tbl.push_back(mk("t5_idle_a",  0, 1,0,0,2,0,      1,0,0,4,0,      1,0));
        tbl.push_back(mk("t5_idle_b",  0, 1,0,0,2,0,      1,0,0,4,0,      0,1));
        for (int a = 0; a < DEPTH; a++)
            tbl.push_back(mk($sformatf("t5_clear%0d", a), 0, 0,0,0,0,0, 1,0,0,a,0, 0,1));
        // Addresses at and beyond DEPTH: writes dropped, reads return zero.
        tbl.push_back(mk("oor_wr9",    0, 1,1,0,9,16'hBEEF, 0,0,0,0,0,    1,0));
        tbl.push_back(mk("oor_rd9",    0, 1,0,0,9,0,      0,0,0,0,0,      1,0));
        tbl.push_back(mk("oor_alias1", 0, 1,0,0,1,0,      0,0,0,0,0,      1,0));
        tbl.push_back(mk("oor_rd15",   0, 1,0,0,15,0,     0,0,0,0,0,      1,0));
        // Read of the last entry immediately after another requester wrote it.
        tbl.push_back(mk("raw_wr7",    0, 0,0,0,0,0,      1,1,0,7,16'h7777, 0,1));
        tbl.push_back(mk("raw_rd7",    0, 1,0,0,7,0,      0,0,0,0,0,      1,0));
        // Simultaneous writes to entry 6 with prio=1, then requester 0 wins.
        tbl.push_back(mk("t6_both",    0, 1,1,0,6,16'h1111, 1,1,0,6,16'h2222, 0,1));
        tbl.push_back(mk("t6_req0",    0, 1,1,0,6,16'h1111, 1,0,0,6,0,    1,0));
        tbl.push_back(mk("t6_rd6",     0, 0,0,0,0,0,      1,0,0,6,0,      0,1));
        tbl.push_back(mk("flush_a",    0, 0,0,0,0,0,      0,0,0,0,0,      0,0));
        tbl.push_back(mk("flush_b",    0, 0,0,0,0,0,      0,0,0,0,0,      0,0));

        foreach (tbl[i]) step(tbl[i]);

        check("scoreboard drained", 32'(q0.size() + q1.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
